agree_predictor: RTL and testbench
==================================

Name: agree_predictor

Overview:
- Fetch-stage branch predictor: an agree-scheme direction predictor plus a direct-mapped branch target buffer (BTB).
- Predicts direction and target for the current fetch PC in the same cycle (combinational lookup).
- Trained by the EX-stage resolved outcome, i.e. the true branch decision and target computed at execute. It is the prediction side of that resolution path.

Parameters:
- BTB_IDX_W, 6, BTB index width; 64 entries; index = pc[BTB_IDX_W+1:2]
- PHT_IDX_W, 8, pattern history table index width; 256 two-bit agree counters
- GHR_W, 8, global history register width; must be <= PHT_IDX_W

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- pc_i  in  32  fetch PC to predict
- pred_hit_o  out  1  BTB hit for pc_i
- pred_taken_o  out  1  predicted taken
- pred_target_o  out  32  predicted target; 0 when no hit
- pred_pht_idx_o  out  PHT_IDX_W  PHT index used for this prediction; carried down the pipeline
- upd_valid_i  in  1  resolved control-flow instruction at EX this cycle
- upd_pc_i  in  32  PC of resolved instruction
- upd_is_br_i  in  1  conditional branch
- upd_is_uncbr_i  in  1  jump (JAL/JALR)
- upd_taken_i  in  1  true branch decision
- upd_target_i  in  32  computed target
- upd_pht_idx_i  in  PHT_IDX_W  pred_pht_idx_o value captured at fetch

Behaviour:
- State, all in flops so reset can clear it:
  - BTB entry: valid, tag = pc[31:BTB_IDX_W+2], target[31:0], uncbr, bias.
  - PHT: 2-bit counters.
  - GHR.
- Reset (async, on rst_i high):
  - All BTB valid = 0; all PHT counters = 2'b10 (weakly agree); GHR = 0.
  - Outputs follow combinationally: pred_hit_o = 0, pred_taken_o = 0, pred_target_o = 0, pred_pht_idx_o = pc_i index ^ 0.
- Lookup (0 latency, combinational):
  - hit = valid[idx] & tag match.
  - pht_idx = pc_i[PHT_IDX_W+1:2] XOR zero-extended GHR.
  - agree = PHT[pht_idx][1].
  - pred_taken_o = hit & (uncbr | ~(bias ^ agree)).
  - pred_target_o = hit ? target : 0.
- Update, on a clock edge when upd_valid_i & (upd_is_br_i | upd_is_uncbr_i):
  - upd_valid_i with neither type flag set: no state change.
  - BTB miss at upd_pc_i (invalid or tag mismatch): allocate/overwrite the entry.
    - valid = 1; tag and target from inputs; uncbr = upd_is_uncbr_i.
    - bias = upd_is_uncbr_i ? 1 : upd_taken_i.
    - PHT not touched.
  - BTB hit: target overwritten with upd_target_i; bias and uncbr unchanged.
    - If conditional: PHT[upd_pht_idx_i] increments when upd_taken_i == bias, else decrements.
    - Counter saturates at 3 and 0.
  - GHR: shifts left with upd_taken_i inserted at bit 0, on conditional branches only (non-speculative). Jumps do not change the GHR.
  - upd_is_br_i and upd_is_uncbr_i both high: treated as jump.
- Simultaneous lookup and update of the same entry: lookup returns the pre-update value; the new value is visible the cycle after the edge.
- Reset asserted mid-training: state clears immediately, without waiting for a clock edge. The first update after release is treated as a miss.
- Direction is never corrected speculatively. Mispredict detection and flush belong to EX, not this block.

Test Plan:
- Reset then pc_i=0x100 -> pred_hit_o=0, pred_taken_o=0, pred_target_o=0; pred_pht_idx_o=0x40.
- Update conditional pc=0x100 taken=1, target=0x200 -> next cycle pc_i=0x100 gives hit=1, taken=1, target=0x200 (bias=1, counter 10). GHR=0x01.
- Three hit updates pc=0x100 taken=0 with upd_pht_idx_i=0x40 -> counter 10->01->00->00 (saturates). Lookup with GHR such that idx=0x40 gives taken=0.
- Jump pc=0x300 target=0x80 -> hit, taken=1 regardless of PHT; GHR unchanged.
- Alias: allocate pc=0x100, then update pc=0x1100 (same BTB index, different tag) -> pc_i=0x100 misses; pc_i=0x1100 hits with new target; PHT unchanged by the allocation.
- Update and lookup same PC in the same cycle -> old result that cycle, new result next cycle. Assert rst_i between edges -> hit drops to 0 immediately.

Source files
------------

// File: rtl/agree_predictor.sv
// Agree-scheme direction predictor with a direct-mapped BTB; combinational lookup and edge-triggered training.
// Latency: prediction in the same cycle as pc_i; training becomes visible the cycle after the update edge.
// Backpressure: none; one lookup and one update are accepted every cycle.
//
// Ports: clk_i/rst_i (async active-high reset); pc_i -> pred_hit_o, pred_taken_o,
// pred_target_o, pred_pht_idx_o (lookup side); upd_* (EX-resolved training side).
module agree_predictor #(
    parameter int BTB_IDX_W = 6,
    parameter int PHT_IDX_W = 8,
    parameter int GHR_W     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          pc_i,
    output logic                 pred_hit_o,
    output logic                 pred_taken_o,
    output logic [31:0]          pred_target_o,
    output logic [PHT_IDX_W-1:0] pred_pht_idx_o,
    input  logic                 upd_valid_i,
    input  logic [31:0]          upd_pc_i,
    input  logic                 upd_is_br_i,
    input  logic                 upd_is_uncbr_i,
    input  logic                 upd_taken_i,
    input  logic [31:0]          upd_target_i,
    input  logic [PHT_IDX_W-1:0] upd_pht_idx_i
);
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int PHT_N = 1 << PHT_IDX_W;
    localparam int TAG_W = 32 - BTB_IDX_W - 2;

    logic             btb_valid_q  [BTB_N];
    logic             btb_valid_d  [BTB_N];
    logic [TAG_W-1:0] btb_tag_q    [BTB_N];
    logic [TAG_W-1:0] btb_tag_d    [BTB_N];
    logic [31:0]      btb_target_q [BTB_N];
    logic [31:0]      btb_target_d [BTB_N];
    logic             btb_uncbr_q  [BTB_N];
    logic             btb_uncbr_d  [BTB_N];
    logic             btb_bias_q   [BTB_N];
    logic             btb_bias_d   [BTB_N];
    logic [1:0]       pht_q        [PHT_N];
    logic [1:0]       pht_d        [PHT_N];
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;

    // Word-aligned PCs never use the low two bits.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_i[1:0], upd_pc_i[1:0]};

    // ---------------- Lookup ----------------
    logic [BTB_IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0]     lk_tag;
    logic [PHT_IDX_W-1:0] ghr_ext;
    logic                 lk_hit;
    logic                 lk_agree;

    assign lk_idx = pc_i[BTB_IDX_W+1:2];
    assign lk_tag = pc_i[31:BTB_IDX_W+2];

    always_comb begin
        ghr_ext              = '0;
        ghr_ext[GHR_W-1:0]   = ghr_q;
    end

    assign pred_pht_idx_o = pc_i[PHT_IDX_W+1:2] ^ ghr_ext;
    assign lk_hit         = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
    assign lk_agree       = pht_q[pred_pht_idx_o][1];

    // Jumps are always taken; branches are taken when the PHT agrees with the stored bias.
    assign pred_hit_o    = lk_hit;
    assign pred_taken_o  = lk_hit && (btb_uncbr_q[lk_idx] || !(btb_bias_q[lk_idx] ^ lk_agree));
    assign pred_target_o = lk_hit ? btb_target_q[lk_idx] : 32'h0;

    // ---------------- Update ----------------
    logic [BTB_IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0]     upd_tag;
    logic                 upd_en;
    logic                 upd_is_cond;
    logic                 upd_hit;

    assign upd_idx     = upd_pc_i[BTB_IDX_W+1:2];
    assign upd_tag     = upd_pc_i[31:BTB_IDX_W+2];
    assign upd_en      = upd_valid_i && (upd_is_br_i || upd_is_uncbr_i);
    // A record flagged as both kinds is trained as a jump.
    assign upd_is_cond = upd_is_br_i && !upd_is_uncbr_i;
    assign upd_hit     = btb_valid_q[upd_idx] && (btb_tag_q[upd_idx] == upd_tag);

    always_comb begin
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        btb_uncbr_d  = btb_uncbr_q;
        btb_bias_d   = btb_bias_q;
        pht_d        = pht_q;
        ghr_d        = ghr_q;
        if (upd_en) begin
            if (!upd_hit) begin
                // Allocation leaves the PHT alone: the counter is shared and not yet trained for this entry.
                btb_valid_d[upd_idx]  = 1'b1;
                btb_tag_d[upd_idx]    = upd_tag;
                btb_target_d[upd_idx] = upd_target_i;
                btb_uncbr_d[upd_idx]  = upd_is_uncbr_i;
                btb_bias_d[upd_idx]   = upd_is_uncbr_i ? 1'b1 : upd_taken_i;
            end else begin
                btb_target_d[upd_idx] = upd_target_i;
                if (upd_is_cond) begin
                    if (upd_taken_i == btb_bias_q[upd_idx]) begin
                        if (pht_q[upd_pht_idx_i] != 2'd3)
                            pht_d[upd_pht_idx_i] = pht_q[upd_pht_idx_i] + 2'd1;
                    end else begin
                        if (pht_q[upd_pht_idx_i] != 2'd0)
                            pht_d[upd_pht_idx_i] = pht_q[upd_pht_idx_i] - 2'd1;
                    end
                end
            end
            if (upd_is_cond)
                ghr_d = {ghr_q[GHR_W-2:0], upd_taken_i};
        end
    end

    // State that reset must clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BTB_N; i++) btb_valid_q[i] <= 1'b0;
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b10;
            ghr_q <= '0;
        end else begin
            btb_valid_q <= btb_valid_d;
            pht_q       <= pht_d;
            ghr_q       <= ghr_d;
        end
    end

    // Entry payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clk_i) begin
        btb_tag_q    <= btb_tag_d;
        btb_target_q <= btb_target_d;
        btb_uncbr_q  <= btb_uncbr_d;
        btb_bias_q   <= btb_bias_d;
    end
endmodule

// File: tb/tb_agree_predictor.sv
// Bench for agree_predictor: directed scenarios plus randomized traffic against an array-based reference model.
// Lookups are checked mid-cycle (before the edge that applies the same cycle's update).
// No backpressure to model; the bench drives one lookup/update pair per cycle.
module tb_agree_predictor;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i;
    logic        pred_hit_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic [7:0]  pred_pht_idx_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_is_br_i;
    logic        upd_is_uncbr_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic [7:0]  upd_pht_idx_i;

    agree_predictor dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i),
        .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o),
        .pred_target_o(pred_target_o), .pred_pht_idx_o(pred_pht_idx_o),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_is_br_i(upd_is_br_i),
        .upd_is_uncbr_i(upd_is_uncbr_i), .upd_taken_i(upd_taken_i),
        .upd_target_i(upd_target_i), .upd_pht_idx_i(upd_pht_idx_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- Reference model ----------------
    bit          m_valid  [64];
    int unsigned m_tag    [64];
    int unsigned m_target [64];
    bit          m_uncbr  [64];
    bit          m_bias   [64];
    int          m_pht    [256];
    int unsigned m_ghr;

    function automatic void m_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 0;
        for (int i = 0; i < 256; i++) m_pht[i] = 2;
        m_ghr = 0;
    endfunction

    function automatic int unsigned m_pidx(input int unsigned pc);
        return ((pc >> 2) % 256) ^ m_ghr;
    endfunction

    function automatic bit m_hit(input int unsigned pc);
        int unsigned i = (pc >> 2) % 64;
        return m_valid[i] && (m_tag[i] == (pc >> 8));
    endfunction

    function automatic void m_update(input bit v, input int unsigned pc, input bit br,
                                     input bit unc, input bit tk, input int unsigned tgt,
                                     input int unsigned pidx);
        int unsigned i = (pc >> 2) % 64;
        bit cond = br && !unc;
        if (!(v && (br || unc))) return;
        if (!m_hit(pc)) begin
            m_valid[i] = 1; m_tag[i] = pc >> 8; m_target[i] = tgt;
            m_uncbr[i] = unc; m_bias[i] = unc ? 1'b1 : tk;
        end else begin
            m_target[i] = tgt;
            if (cond) begin
                if (tk == m_bias[i]) m_pht[pidx] = (m_pht[pidx] == 3) ? 3 : m_pht[pidx] + 1;
                else                 m_pht[pidx] = (m_pht[pidx] == 0) ? 0 : m_pht[pidx] - 1;
            end
        end
        if (cond) m_ghr = ((m_ghr << 1) | tk) % 256;
    endfunction

    task automatic check_lookup(input string tag);
        int unsigned i = (pc_i >> 2) % 64;
        bit hit = m_hit(pc_i);
        bit agree = (m_pht[m_pidx(pc_i)] >= 2);
        bit tk = hit && (m_uncbr[i] || (m_bias[i] == agree));
        chk({tag, ".hit"}, {31'b0, pred_hit_o}, {31'b0, hit});
        chk({tag, ".taken"}, {31'b0, pred_taken_o}, {31'b0, tk});
        chk({tag, ".target"}, pred_target_o, hit ? m_target[i] : 32'h0);
        chk({tag, ".pidx"}, {24'b0, pred_pht_idx_o}, m_pidx(pc_i));
    endtask

    // One cycle: drive at negedge, check the pre-update lookup, then let the edge train both DUT and model.
    task automatic step(input string tag, input int unsigned lpc, input bit v, input int unsigned upc,
                        input bit br, input bit unc, input bit tk, input int unsigned tgt,
                        input int unsigned pidx);
        @(negedge clk_i);
        pc_i = lpc; upd_valid_i = v; upd_pc_i = upc; upd_is_br_i = br;
        upd_is_uncbr_i = unc; upd_taken_i = tk; upd_target_i = tgt; upd_pht_idx_i = pidx[7:0];
        #1 check_lookup(tag);
        @(posedge clk_i);
        m_update(v, upc, br, unc, tk, tgt, pidx);
    endtask

    int unsigned pool [8] = '{32'h100, 32'h1100, 32'h300, 32'h104, 32'h2100, 32'h40, 32'h3fc, 32'h1300};

    initial begin
        rst_i = 1'b1; pc_i = 32'h100; upd_valid_i = 0; upd_pc_i = 0; upd_is_br_i = 0;
        upd_is_uncbr_i = 0; upd_taken_i = 0; upd_target_i = 0; upd_pht_idx_i = 0;
        m_reset();
        #2;
        chk("reset.hit", {31'b0, pred_hit_o}, 32'd0);
        chk("reset.taken", {31'b0, pred_taken_o}, 32'd0);
        chk("reset.target", pred_target_o, 32'd0);
        chk("reset.pidx", {24'b0, pred_pht_idx_o}, 32'h40);
        #10 rst_i = 1'b0;

        // Allocate a taken conditional branch, then observe it.
        step("alloc", 32'h100, 1, 32'h100, 1, 0, 1, 32'h200, 32'h40);
        step("after_alloc", 32'h100, 0, 0, 0, 0, 0, 0, 0);
        chk("ghr_after_alloc", {24'b0, pred_pht_idx_o}, 32'h41);
        // Three not-taken hits against bias=1 drive counter 0x40 to saturation at 0.
        for (int k = 0; k < 3; k++) step("train_nt", 32'h100, 1, 32'h100, 1, 0, 0, 32'h200, 32'h40);
        step("post_train", 32'h100, 0, 0, 0, 0, 0, 0, 0);
        // Valid without type flags changes nothing.
        step("noflag", 32'h100, 1, 32'h100, 0, 0, 1, 32'h999, 32'h40);
        // Jump: always taken, GHR untouched.
        step("jump", 32'h300, 1, 32'h300, 0, 1, 1, 32'h80, 0);
        step("jump_look", 32'h300, 0, 0, 0, 0, 0, 0, 0);
        // Both flags: treated as jump.
        step("both", 32'h304, 1, 32'h304, 1, 1, 0, 32'h90, 0);
        step("both_look", 32'h304, 0, 0, 0, 0, 0, 0, 0);
        // Alias into index of 0x100 with a different tag.
        step("alias", 32'h100, 1, 32'h1100, 1, 0, 1, 32'h400, 32'h40);
        step("alias_old", 32'h100, 0, 0, 0, 0, 0, 0, 0);
        step("alias_new", 32'h1100, 0, 0, 0, 0, 0, 0, 0);
        // Same-cycle lookup and update of one entry.
        step("same_cyc", 32'h1100, 1, 32'h1100, 1, 0, 1, 32'h500, 32'h44);
        step("same_next", 32'h1100, 0, 0, 0, 0, 0, 0, 0);

        // Reset between edges: hit must drop without a clock.
        @(negedge clk_i);
        pc_i = 32'h1100; upd_valid_i = 0;
        #1 chk("pre_rst.hit", {31'b0, pred_hit_o}, 32'd1);
        rst_i = 1'b1;
        #1 chk("mid_rst.hit", {31'b0, pred_hit_o}, 32'd0);
        m_reset();
        rst_i = 1'b0;
        step("post_rst_miss", 32'h1100, 1, 32'h1100, 1, 0, 0, 32'h600, 32'h10);
        step("post_rst_look", 32'h1100, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic over a small PC pool so entries alias and retrain.
        for (int n = 0; n < 400; n++) begin
            int unsigned lpc = pool[$urandom_range(0, 7)];
            int unsigned upc = pool[$urandom_range(0, 7)];
            int unsigned pidx = ($urandom_range(0, 3) != 0) ? m_pidx(upc) : $urandom_range(0, 255);
            step("rand", lpc, $urandom_range(0, 3) != 0, upc, $urandom_range(0, 1),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 1),
                 $urandom & 32'hfffffffc, pidx);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
